ssd_scan_driver: RTL and testbench



---
 rtl/ssd_scan_driver.sv | 176 +++++++++++++++++
 tb/tb_ssd_scan_driver.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ssd_scan_driver.sv
// ssd_scan_driver: time-multiplexed N-digit seven-segment driver with glyph decode,
// frame-synchronous double buffering, blank/blink/dp masks and anode dead-time.
module ssd_scan_driver #(
    parameter int NUM_DIGITS     = 8,
    parameter int SCAN_DIV_BITS  = 17,
    parameter int DEAD_CYCLES    = 64,
    parameter int BLINK_DIV_BITS = 25,
    parameter int GLYPH_W        = 5
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic                          load,
    input  logic [NUM_DIGITS*GLYPH_W-1:0] glyph_in,
    input  logic [NUM_DIGITS-1:0]         blank_in,
    input  logic [NUM_DIGITS-1:0]         blink_in,
    input  logic [NUM_DIGITS-1:0]         dp_in,
    output logic                          load_ack,
    output logic                          frame_start,
    output logic [NUM_DIGITS-1:0]         an,
    output logic [7:0]                    cath
);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [GLYPH_W-1:0] GLYPH_BLANK = GLYPH_W'(16);

    function automatic logic [6:0] seg_of(input logic [GLYPH_W-1:0] g);
        logic [6:0] s;
        s = 7'b1111111;
        case (32'(g))
            32'h00: s = 7'b0000001;
            32'h01: s = 7'b1001111;
            32'h02: s = 7'b0010010;
            32'h03: s = 7'b0000110;
            32'h04: s = 7'b1001100;
            32'h05: s = 7'b0100100;
            32'h06: s = 7'b0100000;
            32'h07: s = 7'b0001111;
            32'h08: s = 7'b0000000;
            32'h09: s = 7'b0000100;
            32'h0A: s = 7'b0001000;
            32'h0B: s = 7'b1100000;
            32'h0C: s = 7'b0110001;
            32'h0D: s = 7'b1000010;
            32'h0E: s = 7'b0110000;
            32'h0F: s = 7'b0111000;
            32'h11: s = 7'b1110001;
            32'h12: s = 7'b1111010;
            32'h13: s = 7'b1111110;
            32'h14: s = 7'b0011000;
            32'h15: s = 7'b1001000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    logic [SCAN_DIV_BITS-1:0]      presc_q, presc_d;
    logic [BLINK_DIV_BITS-1:0]     blink_cnt_q, blink_cnt_d;
    logic [IDX_W-1:0]              idx_q, idx_d;
    logic                          pending_q, pending_d;
    logic [NUM_DIGITS*GLYPH_W-1:0] sh_glyph_q, sh_glyph_d, act_glyph_q, act_glyph_d;
    logic [NUM_DIGITS-1:0]         sh_blank_q, sh_blank_d, act_blank_q, act_blank_d;
    logic [NUM_DIGITS-1:0]         sh_blink_q, sh_blink_d, act_blink_q, act_blink_d;
    logic [NUM_DIGITS-1:0]         sh_dp_q, sh_dp_d, act_dp_q, act_dp_d;
    logic [NUM_DIGITS-1:0]         an_q, an_d;
    logic [7:0]                    cath_q, cath_d;
    logic                          load_ack_q, load_ack_d;
    logic                          frame_start_q, frame_start_d;

    logic                          tick, wrap, visible;
    logic [GLYPH_W-1:0]            cur_glyph;
    logic                          cur_blank, cur_blink, cur_dp;
    logic [NUM_DIGITS-1:0]         onehot;

    always_comb begin
        tick        = (presc_q == '1);
        wrap        = tick && (idx_q == IDX_W'(NUM_DIGITS - 1));
        presc_d     = presc_q + 1'b1;
        blink_cnt_d = blink_cnt_q + 1'b1;
        idx_d       = idx_q;
        if (wrap) begin
            idx_d = '0;
        end else if (tick) begin
            idx_d = idx_q + 1'b1;
        end

        pending_d   = pending_q;
        sh_glyph_d  = sh_glyph_q;
        sh_blank_d  = sh_blank_q;
        sh_blink_d  = sh_blink_q;
        sh_dp_d     = sh_dp_q;
        act_glyph_d = act_glyph_q;
        act_blank_d = act_blank_q;
        act_blink_d = act_blink_q;
        act_dp_d    = act_dp_q;
        load_ack_d  = 1'b0;
        // Copy uses the old shadow, so a load on the wrap cycle waits one frame.
        if (wrap && pending_q) begin
            act_glyph_d = sh_glyph_q;
            act_blank_d = sh_blank_q;
            act_blink_d = sh_blink_q;
            act_dp_d    = sh_dp_q;
            pending_d   = 1'b0;
            load_ack_d  = 1'b1;
        end
        if (load) begin
            sh_glyph_d = glyph_in;
            sh_blank_d = blank_in;
            sh_blink_d = blink_in;
            sh_dp_d    = dp_in;
            pending_d  = 1'b1;
        end
        frame_start_d = wrap;

        cur_glyph = GLYPH_BLANK;
        cur_blank = 1'b0;
        cur_blink = 1'b0;
        cur_dp    = 1'b0;
        onehot    = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_glyph = act_glyph_q[i*GLYPH_W +: GLYPH_W];
                cur_blank = act_blank_q[i];
                cur_blink = act_blink_q[i];
                cur_dp    = act_dp_q[i];
                onehot[i] = 1'b1;
            end
        end
        visible = enable && !cur_blank && !(cur_blink && blink_cnt_q[BLINK_DIV_BITS-1])
                  && (presc_q >= SCAN_DIV_BITS'(DEAD_CYCLES));
        an_d    = visible ? ~onehot : '1;
        cath_d  = visible ? {seg_of(cur_glyph), ~cur_dp} : 8'hFF;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q       <= '0;
            blink_cnt_q   <= '0;
            idx_q         <= '0;
            pending_q     <= 1'b0;
            sh_glyph_q    <= {NUM_DIGITS{GLYPH_BLANK}};
            sh_blank_q    <= '0;
            sh_blink_q    <= '0;
            sh_dp_q       <= '0;
            act_glyph_q   <= {NUM_DIGITS{GLYPH_BLANK}};
            act_blank_q   <= '0;
            act_blink_q   <= '0;
            act_dp_q      <= '0;
            an_q          <= '1;
            cath_q        <= 8'hFF;
            load_ack_q    <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            presc_q       <= presc_d;
            blink_cnt_q   <= blink_cnt_d;
            idx_q         <= idx_d;
            pending_q     <= pending_d;
            sh_glyph_q    <= sh_glyph_d;
            sh_blank_q    <= sh_blank_d;
            sh_blink_q    <= sh_blink_d;
            sh_dp_q       <= sh_dp_d;
            act_glyph_q   <= act_glyph_d;
            act_blank_q   <= act_blank_d;
            act_blink_q   <= act_blink_d;
            act_dp_q      <= act_dp_d;
            an_q          <= an_d;
            cath_q        <= cath_d;
            load_ack_q    <= load_ack_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign an          = an_q;
    assign cath        = cath_q;
    assign load_ack    = load_ack_q;
    assign frame_start = frame_start_q;
endmodule

// File: tb/tb_ssd_scan_driver.sv
// Self-checking bench for ssd_scan_driver: directed sequences, a glyph vector table
// and randomized traffic against a cycle-count based reference model.
module tb_ssd_scan_driver;
    localparam int ND = 4;
    localparam int SDB = 2;
    localparam int DC = 1;
    localparam int BDB = 5;
    localparam int GW = 5;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              enable = 1'b0;
    logic              load = 1'b0;
    logic [ND*GW-1:0]  glyph_in = '0;
    logic [ND-1:0]     blank_in = '0;
    logic [ND-1:0]     blink_in = '0;
    logic [ND-1:0]     dp_in = '0;
    logic              load_ack, frame_start;
    logic [ND-1:0]     an;
    logic [7:0]        cath;

    int tests = 0;
    int fails = 0;
    int ack_cnt = 0;
    int fs_cnt = 0;

    always #5 clk = ~clk;

    ssd_scan_driver #(
        .NUM_DIGITS(ND), .SCAN_DIV_BITS(SDB), .DEAD_CYCLES(DC),
        .BLINK_DIV_BITS(BDB), .GLYPH_W(GW)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .load(load),
        .glyph_in(glyph_in), .blank_in(blank_in), .blink_in(blink_in), .dp_in(dp_in),
        .load_ack(load_ack), .frame_start(frame_start), .an(an), .cath(cath)
    );

    // Reference model: n = clock cycles since reset released; slot, digit and blink
    // phase follow from n by plain arithmetic.
    int            n = 0;
    logic          m_pend = 1'b0;
    logic [GW-1:0] m_act_gl [ND];
    logic [GW-1:0] m_sh_gl [ND];
    logic [ND-1:0] m_act_bl, m_act_bk, m_act_dp, m_sh_bl, m_sh_bk, m_sh_dp;
    logic [6:0]    seg_rom [22];

    function automatic logic [6:0] m_seg(input logic [GW-1:0] code);
        int c;
        c = int'(code);
        return (c < 22) ? seg_rom[c] : 7'b1111111;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h (n=%0d)", name, act, exp, n);
        end
    endtask

    task automatic step();
        int p, d;
        logic ph, vis, wrap;
        logic [ND-1:0] e_an;
        logic [7:0] e_cath;
        logic e_ack, e_fs;
        if (rst) begin
            e_an = '1; e_cath = 8'hFF; e_ack = 1'b0; e_fs = 1'b0;
            n = 0;
            m_pend = 1'b0;
            for (int i = 0; i < ND; i++) m_act_gl[i] = 5'h10;
            m_act_bl = '0; m_act_bk = '0; m_act_dp = '0;
        end else begin
            p    = n % (1 << SDB);
            d    = (n / (1 << SDB)) % ND;
            ph   = (n % (1 << BDB)) >= (1 << (BDB - 1));
            vis  = enable && !m_act_bl[d] && !(m_act_bk[d] && ph) && (p >= DC);
            e_an = vis ? ~(ND'(1) << d) : '1;
            e_cath = vis ? {m_seg(m_act_gl[d]), ~m_act_dp[d]} : 8'hFF;
            wrap = (n % ((1 << SDB) * ND)) == ((1 << SDB) * ND - 1);
            e_fs = wrap;
            e_ack = wrap && m_pend;
            if (e_ack) begin
                m_act_gl = m_sh_gl;
                m_act_bl = m_sh_bl; m_act_bk = m_sh_bk; m_act_dp = m_sh_dp;
                m_pend = 1'b0;
            end
            if (load) begin
                for (int i = 0; i < ND; i++) m_sh_gl[i] = glyph_in[i*GW +: GW];
                m_sh_bl = blank_in; m_sh_bk = blink_in; m_sh_dp = dp_in;
                m_pend = 1'b1;
            end
            n++;
        end
        @(posedge clk);
        #1;
        check("an", 32'(an), 32'(e_an));
        check("cath", 32'(cath), 32'(e_cath));
        check("load_ack", 32'(load_ack), 32'(e_ack));
        check("frame_start", 32'(frame_start), 32'(e_fs));
        if (load_ack === 1'b1) ack_cnt++;
        if (frame_start === 1'b1) fs_cnt++;
    endtask

    task automatic run_to(input int target);
        while (n < target && !rst) step();
    endtask

    task automatic do_load(input logic [ND*GW-1:0] g, input logic [ND-1:0] bl,
                           input logic [ND-1:0] bk, input logic [ND-1:0] dp);
        glyph_in = g; blank_in = bl; blink_in = bk; dp_in = dp; load = 1'b1;
        step();
        load = 1'b0;
    endtask

    typedef struct {
        logic [GW-1:0] code;
        logic          dp;
        logic [7:0]    exp_cath;
    } vec_t;
    vec_t vecs [24];

    initial begin
        seg_rom[0]  = 7'b0000001; seg_rom[1]  = 7'b1001111; seg_rom[2]  = 7'b0010010;
        seg_rom[3]  = 7'b0000110; seg_rom[4]  = 7'b1001100; seg_rom[5]  = 7'b0100100;
        seg_rom[6]  = 7'b0100000; seg_rom[7]  = 7'b0001111; seg_rom[8]  = 7'b0000000;
        seg_rom[9]  = 7'b0000100; seg_rom[10] = 7'b0001000; seg_rom[11] = 7'b1100000;
        seg_rom[12] = 7'b0110001; seg_rom[13] = 7'b1000010; seg_rom[14] = 7'b0110000;
        seg_rom[15] = 7'b0111000; seg_rom[16] = 7'b1111111; seg_rom[17] = 7'b1110001;
        seg_rom[18] = 7'b1111010; seg_rom[19] = 7'b1111110; seg_rom[20] = 7'b0011000;
        seg_rom[21] = 7'b1001000;

        vecs[0]  = '{5'h00, 1'b0, 8'b00000011}; vecs[1]  = '{5'h01, 1'b1, 8'b10011110};
        vecs[2]  = '{5'h02, 1'b0, 8'b00100101}; vecs[3]  = '{5'h03, 1'b0, 8'b00001101};
        vecs[4]  = '{5'h04, 1'b0, 8'b10011001}; vecs[5]  = '{5'h05, 1'b0, 8'b01001001};
        vecs[6]  = '{5'h06, 1'b0, 8'b01000001}; vecs[7]  = '{5'h07, 1'b0, 8'b00011111};
        vecs[8]  = '{5'h08, 1'b1, 8'b00000000}; vecs[9]  = '{5'h09, 1'b0, 8'b00001001};
        vecs[10] = '{5'h0A, 1'b0, 8'b00010001}; vecs[11] = '{5'h0B, 1'b0, 8'b11000001};
        vecs[12] = '{5'h0C, 1'b0, 8'b01100011}; vecs[13] = '{5'h0D, 1'b0, 8'b10000101};
        vecs[14] = '{5'h0E, 1'b0, 8'b01100001}; vecs[15] = '{5'h0F, 1'b0, 8'b01110001};
        vecs[16] = '{5'h10, 1'b1, 8'b11111110}; vecs[17] = '{5'h11, 1'b0, 8'b11100011};
        vecs[18] = '{5'h12, 1'b0, 8'b11110101}; vecs[19] = '{5'h13, 1'b0, 8'b11111101};
        vecs[20] = '{5'h14, 1'b0, 8'b00110001}; vecs[21] = '{5'h15, 1'b0, 8'b10010001};
        vecs[22] = '{5'h16, 1'b0, 8'b11111111}; vecs[23] = '{5'h1F, 1'b1, 8'b11111110};

        // Reset and blank startup frame
        rst = 1'b1;
        repeat (3) step();
        check("reset_an", 32'(an), 32'(4'b1111));
        check("reset_cath", 32'(cath), 32'(8'hFF));
        check("reset_ack", 32'(load_ack), 32'(1'b0));
        rst = 1'b0; enable = 1'b1;
        run_to(16);

        // Single load, applied at the next boundary
        ack_cnt = 0;
        do_load({5'h13, 5'h0F, 5'h11, 5'h12}, 4'b0000, 4'b0000, 4'b0000);
        run_to(34);
        check("d0_an", 32'(an), 32'(4'b1110));
        check("d0_cath", 32'(cath), 32'(8'b11110101));
        run_to(37);
        check("dead_slot_an", 32'(an), 32'(4'b1111));
        run_to(38);
        check("d1_an", 32'(an), 32'(4'b1101));
        check("d1_cath", 32'(cath), 32'(8'b11100011));
        run_to(48);
        check("single_ack", 32'(ack_cnt), 32'(1));

        // Double load: second set wins, one ack
        ack_cnt = 0;
        do_load({ND{5'h01}}, 4'b0000, 4'b0000, 4'b0000);
        step();
        do_load({5'h15, 5'h14, 5'h0A, 5'h05}, 4'b0000, 4'b0000, 4'b0000);
        run_to(66);
        check("dbl_d0_cath", 32'(cath), 32'(8'b01001001));
        run_to(80);
        check("dbl_single_ack", 32'(ack_cnt), 32'(1));

        // Blink and decimal point
        do_load({5'h00, 5'h00, 5'h03, 5'h08}, 4'b0000, 4'b0001, 4'b0010);
        run_to(98);
        check("blink_ph0_cath", 32'(cath), 32'(8'b00000001));
        run_to(102);
        check("dp_d1_cath", 32'(cath), 32'(8'b00001100));
        run_to(114);
        check("blink_ph1_an", 32'(an), 32'(4'b1111));
        check("blink_ph1_cath", 32'(cath), 32'(8'hFF));
        run_to(118);
        check("dp_d1_ph1_cath", 32'(cath), 32'(8'b00001100));
        run_to(130);
        check("blink_back_cath", 32'(cath), 32'(8'b00000001));

        // Enable off: anodes dark, frame pulses continue
        enable = 1'b0; fs_cnt = 0;
        for (int k = 0; k < 32; k++) begin
            step();
            check("en_off_an", 32'(an), 32'(4'b1111));
        end
        check("en_off_fs_cnt", 32'(fs_cnt), 32'(2));
        enable = 1'b1;

        // Reset in the middle of digit2's slot
        run_to(170);
        rst = 1'b1; step(); rst = 1'b0;
        step();
        check("rst_dead_an", 32'(an), 32'(4'b1111));
        step();
        check("rst_digit0_an", 32'(an), 32'(4'b1110));
        check("rst_blank_cath", 32'(cath), 32'(8'hFF));

        // Invalid code and blank mask override
        run_to(16);
        do_load({5'h07, 5'h0C, 5'h1F, 5'h00}, 4'b0100, 4'b0000, 4'b0000);
        run_to(34);
        check("inv_d0_cath", 32'(cath), 32'(8'b00000011));
        run_to(38);
        check("inv_d1_an", 32'(an), 32'(4'b1101));
        check("inv_d1_cath", 32'(cath), 32'(8'hFF));
        run_to(42);
        check("blank_d2_an", 32'(an), 32'(4'b1111));
        check("blank_d2_cath", 32'(cath), 32'(8'hFF));
        run_to(46);
        check("d3_an", 32'(an), 32'(4'b0111));
        check("d3_cath", 32'(cath), 32'(8'b00011111));

        // Glyph table vectors on digit 0
        foreach (vecs[v]) begin
            do_load({15'h0, vecs[v].code}, 4'b0000, 4'b0000, {3'b000, vecs[v].dp});
            run_to(((n / 16) + 1) * 16 + 2);
            check("vec_an", 32'(an), 32'(4'b1110));
            check($sformatf("vec_cath_%0h", vecs[v].code), 32'(cath), 32'(vecs[v].exp_cath));
        end

        // Randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            rst      = ($urandom_range(0, 99) == 0);
            enable   = ($urandom_range(0, 7) != 0);
            load     = ($urandom_range(0, 5) == 0);
            glyph_in = (ND*GW)'($urandom);
            blank_in = ND'($urandom & $urandom);
            blink_in = ND'($urandom);
            dp_in    = ND'($urandom);
            step();
        end
        rst = 1'b0; load = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
